serializer_8x1: RTL and testbench

SERIALIZER_8X1 -- requirements
Module: serializer_8x1

---
 rtl/serializer_pkg.sv | 27 ++
 rtl/mux_8x1.sv | 12 +
 rtl/serializer_8x1.sv | 94 +++++++++
 tb/tb_serializer_8x1.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// rtl/serializer_pkg.sv - shared types, widths and select-sequencing helpers for serializer_8x1
package serializer_pkg;

    localparam int WORD_W = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Index of the first bit presented for a freshly accepted word.
    function automatic logic [SEL_W-1:0] first_sel(input logic lsb_first);
        return lsb_first ? SEL_W'(0) : SEL_W'(WORD_W - 1);
    endfunction

    // Index of the final bit of a word; the counter stops here instead of wrapping.
    function automatic logic [SEL_W-1:0] last_sel(input logic lsb_first);
        return lsb_first ? SEL_W'(WORD_W - 1) : SEL_W'(0);
    endfunction

    function automatic logic [SEL_W-1:0] step_sel(input logic [SEL_W-1:0] sel,
                                                  input logic             lsb_first);
        return lsb_first ? sel + SEL_W'(1) : sel - SEL_W'(1);
    endfunction

endpackage

// File: rtl/mux_8x1.sv
// rtl/mux_8x1.sv - 8-to-1 bit multiplexer selecting in[sel]
module mux_8x1
    import serializer_pkg::*;
(
    input  logic [WORD_W-1:0] in,
    input  logic [SEL_W-1:0]  sel,
    output logic              y
);

    assign y = in[sel];

endmodule

// File: rtl/serializer_8x1.sv
// rtl/serializer_8x1.sv - 8-bit parallel-to-serial converter with ready/valid on both sides
module serializer_8x1
    import serializer_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in,
    output logic              in_ready,
    input  logic              ser_ready,
    output logic [SEL_W-1:0]  sel,
    output logic              y,
    output logic              ser_valid,
    output logic              last
);

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   held_word_q, held_word_d;
    logic [SEL_W-1:0]    sel_q, sel_d;

    logic                in_shift;
    logic                at_last;
    logic                handoff;
    logic                accept;

    assign in_shift = (state_q == SHIFT);
    assign at_last  = in_shift && (sel_q == last_sel(LSB_FIRST));
    assign handoff  = at_last && ser_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            held_word_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            held_word_q <= held_word_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (handoff) state_d = in_valid ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A handoff with a new word reloads sel directly, so the count never wraps.
    always_comb begin
        held_word_d = held_word_q;
        sel_d       = sel_q;
        if (accept) begin
            held_word_d = in;
            sel_d       = first_sel(LSB_FIRST);
        end else if (in_shift && ser_ready && !at_last) begin
            sel_d       = step_sel(sel_q, LSB_FIRST);
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        ser_valid = 1'b0;
        last      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            SHIFT: begin
                ser_valid = 1'b1;
                last      = at_last;
                in_ready  = handoff;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    assign sel = sel_q;

    mux_8x1 u_mux (
        .in  (held_word_q),
        .sel (sel_q),
        .y   (y)
    );

endmodule

// File: tb/tb_serializer_8x1.sv
// tb/tb_serializer_8x1.sv - directed self-checking bench for both bit orders of serializer_8x1
module tb_serializer_8x1;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] din;
    logic       ser_ready;

    logic       l_in_ready, l_y, l_ser_valid, l_last;
    logic [2:0] l_sel;
    logic       m_in_ready, m_y, m_ser_valid, m_last;
    logic [2:0] m_sel;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    serializer_8x1 #(.LSB_FIRST(1'b1)) dut_lsb (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in        (din),
        .in_ready  (l_in_ready),
        .ser_ready (ser_ready),
        .sel       (l_sel),
        .y         (l_y),
        .ser_valid (l_ser_valid),
        .last      (l_last)
    );

    serializer_8x1 #(.LSB_FIRST(1'b0)) dut_msb (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in        (din),
        .in_ready  (m_in_ready),
        .ser_ready (ser_ready),
        .sel       (m_sel),
        .y         (m_y),
        .ser_valid (m_ser_valid),
        .last      (m_last)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packed view per cycle: {sel, y, ser_valid, last, in_ready}
    task automatic test_reset();
        logic [6:0] obs;
        rst = 1'b1; in_valid = 1'b0; din = 8'h00; ser_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        obs = {l_sel, l_y, l_ser_valid, l_last, l_in_ready};
        total_cnt++;
        if (obs !== 7'b000_0001) $display("FAIL reset_lsb obs=%b exp=%b", obs, 7'b000_0001);
        else pass_cnt++;
        obs = {m_sel, m_y, m_ser_valid, m_last, m_in_ready};
        total_cnt++;
        if (obs !== 7'b000_0001) $display("FAIL reset_msb obs=%b exp=%b", obs, 7'b000_0001);
        else pass_cnt++;
    endtask

    task automatic test_lsb_first();
        int         exp_y[8] = '{1, 1, 1, 0, 0, 1, 0, 1};
        logic [6:0] obs, exp;
        din = 8'b1010_0111; in_valid = 1'b1; ser_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            obs = {l_sel, l_y, l_ser_valid, l_last, l_in_ready};
            exp = {3'(i), exp_y[i][0], 1'b1, (i == 7), (i == 7)};
            total_cnt++;
            if (obs !== exp) $display("FAIL lsb_bit%0d obs=%b exp=%b", i, obs, exp);
            else pass_cnt++;
            tick();
        end
        #1;
        total_cnt++;
        if ({l_ser_valid, l_last, l_in_ready} !== 3'b001)
            $display("FAIL lsb_idle obs=%b exp=001", {l_ser_valid, l_last, l_in_ready});
        else pass_cnt++;
    endtask

    task automatic test_msb_first();
        int         exp_y[8] = '{1, 0, 1, 0, 0, 1, 1, 1};
        logic [6:0] obs, exp;
        din = 8'b1010_0111; in_valid = 1'b1; ser_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            obs = {m_sel, m_y, m_ser_valid, m_last, m_in_ready};
            exp = {3'(7 - i), exp_y[i][0], 1'b1, (i == 7), (i == 7)};
            total_cnt++;
            if (obs !== exp) $display("FAIL msb_bit%0d obs=%b exp=%b", i, obs, exp);
            else pass_cnt++;
            tick();
        end
        #1;
        total_cnt++;
        if ({m_ser_valid, m_last, m_in_ready} !== 3'b001)
            $display("FAIL msb_idle obs=%b exp=001", {m_ser_valid, m_last, m_in_ready});
        else pass_cnt++;
    endtask

    task automatic test_stall();
        int         exp_y[8] = '{1, 1, 1, 0, 0, 1, 0, 1};
        logic [6:0] obs, exp;
        din = 8'b1010_0111; in_valid = 1'b1; ser_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                ser_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    #1;
                    obs = {l_sel, l_y, l_ser_valid, l_last, l_in_ready};
                    total_cnt++;
                    if (obs !== 7'b011_0100) $display("FAIL stall%0d obs=%b exp=%b", s, obs, 7'b011_0100);
                    else pass_cnt++;
                    tick();
                end
                ser_ready = 1'b1;
            end
            #1;
            obs = {l_sel, l_y, l_ser_valid, l_last, l_in_ready};
            exp = {3'(i), exp_y[i][0], 1'b1, (i == 7), (i == 7)};
            total_cnt++;
            if (obs !== exp) $display("FAIL stall_bit%0d obs=%b exp=%b", i, obs, exp);
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int         a5_y[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
        int         c3_y[8] = '{0, 0, 1, 1, 1, 1, 0, 0};
        logic [6:0] obs, exp;
        int         b;
        din = 8'hA5; in_valid = 1'b1; ser_ready = 1'b1;
        tick();
        din = 8'h3C;
        for (int c = 0; c < 16; c++) begin
            if (c == 15) in_valid = 1'b0;
            #1;
            b = (c < 8) ? a5_y[c] : c3_y[c - 8];
            obs = {l_sel, l_y, l_ser_valid, l_last, l_in_ready};
            exp = {3'(c % 8), b[0], 1'b1, (c % 8 == 7), (c % 8 == 7)};
            total_cnt++;
            if (obs !== exp) $display("FAIL b2b_lsb%0d obs=%b exp=%b", c, obs, exp);
            else pass_cnt++;
            obs = {m_sel, m_y, m_ser_valid, m_last, m_in_ready};
            exp = {3'(7 - c % 8), b[0], 1'b1, (c % 8 == 7), (c % 8 == 7)};
            total_cnt++;
            if (obs !== exp) $display("FAIL b2b_msb%0d obs=%b exp=%b", c, obs, exp);
            else pass_cnt++;
            tick();
        end
        #1;
        total_cnt++;
        if ({l_ser_valid, m_ser_valid} !== 2'b00)
            $display("FAIL b2b_idle obs=%b exp=00", {l_ser_valid, m_ser_valid});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        logic [6:0] obs;
        din = 8'b1010_0111; in_valid = 1'b1; ser_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick(); tick();
        total_cnt++;
        if (l_sel !== 3'd4) $display("FAIL rstmid_pre sel=%0d exp=4", l_sel);
        else pass_cnt++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            obs = {l_sel, l_y, l_ser_valid, l_last, l_in_ready};
            total_cnt++;
            if (obs !== 7'b000_0001) $display("FAIL rstmid_lsb%0d obs=%b exp=%b", k, obs, 7'b000_0001);
            else pass_cnt++;
            obs = {m_sel, m_y, m_ser_valid, m_last, m_in_ready};
            total_cnt++;
            if (obs !== 7'b000_0001) $display("FAIL rstmid_msb%0d obs=%b exp=%b", k, obs, 7'b000_0001);
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_ignore_busy_input();
        logic [6:0] obs, exp;
        din = 8'h00; in_valid = 1'b1; ser_ready = 1'b1;
        tick();
        din = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) in_valid = 1'b0;
            #1;
            obs = {l_sel, l_y, l_ser_valid, l_last, l_in_ready};
            exp = {3'(i), 1'b0, 1'b1, (i == 7), (i == 7)};
            total_cnt++;
            if (obs !== exp) $display("FAIL ignore_lsb%0d obs=%b exp=%b", i, obs, exp);
            else pass_cnt++;
            total_cnt++;
            if (m_y !== 1'b0) $display("FAIL ignore_msb%0d y=%b exp=0", i, m_y);
            else pass_cnt++;
            tick();
        end
        #1;
        total_cnt++;
        if ({l_ser_valid, l_in_ready} !== 2'b01)
            $display("FAIL ignore_idle obs=%b exp=01", {l_ser_valid, l_in_ready});
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_stall();
        test_back_to_back();
        test_reset_mid_frame();
        test_ignore_busy_input();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
